// File: rtl/gate_bist.sv
// gate_bist: self-test engine for one two-input gate under test (GUT).
//
// The engine drives the GUT inputs through the patterns {A,B} = 00, 01, 10, 11.
// Each pattern is held for a settle window. The GUT output is then sampled and
// compared against the TRUTH table, whose bit index is {A,B}. Mismatching
// patterns are recorded. At the end of the sweep the engine pulses done and
// reports pass.
//
// Parameters:
//   TRUTH  - expected GUT output for each pattern (default OR = 4'b1110)
//   SETTLE - number of cycles a pattern is held before sampling (1..15)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle sweep request; ignored unless idle
//   a_out     out  drive to GUT input A
//   b_out     out  drive to GUT input B
//   z_in      in   GUT output
//   busy      out  high while a sweep is in progress
//   done      out  one-cycle pulse when a sweep completes
//   pass      out  last completed sweep had zero mismatches (held until next start)
//   err_count out  number of mismatching patterns (0..4)
//   fail_vec  out  bit p set if pattern p mismatched
//   state_dbg out  current FSM state (IDLE=0, HOLD=1, SAMPLE=2, FIN=3)
//
// Optional build macro:
//   GATE_BIST_SYNC_EN - z_in passes through a 2-flop synchronizer (reset to 0)
//                       before comparison. HOLD is stretched to SETTLE+2 cycles,
//                       so the synchronized sample belongs to the current pattern.
//
// Handshake: start is a level that is sampled at each rising edge. It is
// accepted only in IDLE, and busy rises in the cycle after acceptance. done is
// a single-cycle pulse that is issued one cycle after busy falls. A start that
// is held high is accepted again in the cycle after done.

module gate_bist #(
  parameter logic [3:0] TRUTH  = 4'b1110,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       z_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } state_t;

`ifdef GATE_BIST_SYNC_EN
  // Two extra hold cycles cover the synchronizer delay.
  localparam int HOLD_LEN = SETTLE + 2;
`else
  localparam int HOLD_LEN = SETTLE;
`endif
  localparam logic [4:0] HOLD_LAST = 5'(HOLD_LEN - 1);

  state_t     state;
  logic [1:0] pattern;
  logic [4:0] cnt;
  logic       z_cmp;

`ifdef GATE_BIST_SYNC_EN
  logic z_s1, z_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_s1 <= 1'b0;
      z_s2 <= 1'b0;
    end else begin
      z_s1 <= z_in;
      z_s2 <= z_s1;
    end
  end

  assign z_cmp = z_s2;
`else
  assign z_cmp = z_in;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pattern   <= 2'd0;
      cnt       <= 5'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      // done is a pulse, so it is cleared every cycle unless FIN raises it.
      done <= 1'b0;
      case (state)
        IDLE: begin
          a_out <= 1'b0;
          b_out <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
            pattern   <= 2'd0;
            cnt       <= 5'd0;
            busy      <= 1'b1;
            state     <= HOLD;
          end
        end

        HOLD: begin
          a_out <= pattern[1];
          b_out <= pattern[0];
          if (cnt == HOLD_LAST) begin
            cnt   <= 5'd0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        SAMPLE: begin
          if (z_cmp != TRUTH[pattern]) begin
            err_count         <= err_count + 3'd1;
            fail_vec[pattern] <= 1'b1;
          end
          if (pattern == 2'd3) begin
            // The sweep ends here. busy drops and the drives return to 00
            // before the FIN cycle.
            busy  <= 1'b0;
            a_out <= 1'b0;
            b_out <= 1'b0;
            state <= FIN;
          end else begin
            // The next pattern is driven from the following cycle onward.
            pattern <= pattern + 2'd1;
            a_out   <= pattern_next_a(pattern);
            b_out   <= pattern_next_b(pattern);
            cnt     <= 5'd0;
            state   <= HOLD;
          end
        end

        FIN: begin
          done  <= 1'b1;
          pass  <= (err_count == 3'd0);
          busy  <= 1'b0;
          a_out <= 1'b0;
          b_out <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic pattern_next_a(input logic [1:0] p);
    logic [1:0] n;
    n = p + 2'd1;
    return n[1];
  endfunction

  function automatic logic pattern_next_b(input logic [1:0] p);
    logic [1:0] n;
    n = p + 2'd1;
    return n[0];
  endfunction

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed bench for gate_bist. It uses the default parameters
// (TRUTH = OR, SETTLE = 2). The GUT is modelled in the bench and can be an
// OR gate, an output stuck at 0, an AND gate, or an output stuck at 1.

module tb_gate_bist;

  localparam int SETTLE = 2;
`ifdef GATE_BIST_SYNC_EN
  localparam int PER = SETTLE + 3;
`else
  localparam int PER = SETTLE + 1;
`endif
  localparam int LAT = 4 * PER + 1;

  localparam int GUT_OR   = 0;
  localparam int GUT_ZERO = 1;
  localparam int GUT_AND  = 2;
  localparam int GUT_ONE  = 3;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       a_out, b_out;
  logic       z_in;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [1:0] state_dbg;

  int gut_mode;
  int n_tests;
  int n_fail;

  gate_bist #(.TRUTH(4'b1110), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .z_in      (z_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test model
  always_comb begin
    z_in = 1'b0;
    case (gut_mode)
      GUT_OR:   z_in = a_out | b_out;
      GUT_ZERO: z_in = 1'b0;
      GUT_AND:  z_in = a_out & b_out;
      GUT_ONE:  z_in = 1'b1;
      default:  z_in = 1'b0;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Idle window: done must not fire and busy must stay low.
  task automatic idle_watch(input string tag, input int cycles);
    int extra;
    extra = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check_val(tag, extra, 0);
  endtask

  // One full sweep. Optional extra start pulses are injected at cycles 4 and 9.
  task automatic run_sweep(input string name, input int m, input int exp_err,
                           input logic [3:0] exp_vec, input logic exp_pass,
                           input bit extra_starts);
    int k, lat, seq_bad;
    bit got;
    gut_mode = m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;          // the edge that samples start is cycle 0
    start = 1'b0;
    k = 0; lat = 0; seq_bad = 0; got = 0;
    while (!got && k < LAT + 10) begin
      if (k < 4 * PER) begin
        if ({a_out, b_out} != 2'(k / PER) || !busy || done) seq_bad++;
      end
      if (done) begin
        got = 1;
        lat = k;
      end else begin
        start = extra_starts && (k == 3 || k == 8);   // sampled at edges 4 and 9
        @(posedge clk); #1;
        start = 1'b0;
        k++;
      end
    end
    check_val({name, "_lat"}, lat, LAT);
    check_val({name, "_seq"}, seq_bad, 0);
    check_val({name, "_err"}, err_count, exp_err);
    check_val({name, "_vec"}, fail_vec, exp_vec);
    check_val({name, "_pass"}, pass, exp_pass);
    check_val({name, "_ab_busy_end"}, {a_out, b_out, busy}, 0);
    idle_watch({name, "_no_redone"}, 20);
  endtask

  initial begin
    int d1, d2, k;
    bit pass_ok;
    n_tests  = 0;
    n_fail   = 0;
    gut_mode = GUT_OR;
    start    = 1'b0;
    rst_n    = 1'b1;
    #2;
    do_reset();
    #1;
    check_val("reset_outs", {a_out, b_out, busy, done, pass, err_count, fail_vec, state_dbg}, 0);

    run_sweep("or",   GUT_OR,   0, 4'b0000, 1'b1, 1'b0);
    run_sweep("zero", GUT_ZERO, 3, 4'b1110, 1'b0, 1'b0);
    run_sweep("and",  GUT_AND,  2, 4'b0110, 1'b0, 1'b0);
    run_sweep("one",  GUT_ONE,  1, 4'b0001, 1'b0, 1'b0);

    // Extra start pulses during a sweep are ignored.
    do_reset();
    run_sweep("extra_start", GUT_OR, 0, 4'b0000, 1'b1, 1'b1);

    // Reset in the middle of a sweep aborts without a done pulse.
    gut_mode = GUT_ZERO;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2 * PER) @(posedge clk);
    #1;
    check_val("mid_err_before_rst", err_count, 1);
    check_val("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_outs", {a_out, b_out, busy, done, pass, err_count, fail_vec, state_dbg}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_watch("mid_rst_no_done", 20);
    run_sweep("after_rst", GUT_OR, 0, 4'b0000, 1'b1, 1'b0);

    // A start held high gives back-to-back sweeps.
    gut_mode = GUT_OR;
    d1 = 0; d2 = 0; pass_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    for (k = 0; k < 2 * LAT + 4; k++) begin
      if (done) begin
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
        if (!pass) pass_ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_val("b2b_done1", d1, LAT);
    check_val("b2b_done2", d2, 2 * LAT + 1);
    check_val("b2b_pass", pass_ok, 1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected earlier end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Synthesizable self-test engine for one two-input gate under test (GUT), such as prim_or.
- It drives the GUT inputs through all four patterns in the order {A,B} = 00, 01, 10, 11.
- After each pattern settles, it samples the GUT output and compares it against an expected truth table.
- It records mismatches and reports done/pass. This puts the stimulus/check role in hardware, on the opposite side of the gate interface from the gate itself.

Parameters:
- TRUTH, 4'b1110, expected output per pattern; bit index = {A,B}. Default is OR; AND = 4'b1000.
- SETTLE, 2, cycles the pattern is held before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a sweep; ignored unless the block is idle
- a_out  output  1  drive to GUT input A
- b_out  output  1  drive to GUT input B
- z_in  input  1  GUT output
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when the sweep completes
- pass  output  1  high if the last completed sweep had zero mismatches; held until the next start
- err_count  output  3  number of mismatching patterns in the current/last sweep (0..4)
- fail_vec  output  4  bit p set if pattern p mismatched

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; a_out=b_out=0; busy=0; done=0; pass=0; err_count=0; fail_vec=0; pattern=0; settle counter=0.
- Reset asserted mid-sweep aborts immediately to the reset values. No done pulse is produced.
- States: IDLE, HOLD, SAMPLE, FIN. All outputs are registered.
- IDLE:
  - {a_out,b_out} = 00; busy=0.
  - On start=1 at a rising edge: clear err_count and fail_vec, set pattern=0, drive {a_out,b_out}=00, set busy=1, go to HOLD with cnt=0.
- HOLD:
  - {a_out,b_out} = pattern.
  - cnt increments each cycle. When cnt==SETTLE-1, go to SAMPLE.
- SAMPLE (one cycle):
  - Compare z_in with TRUTH[pattern].
  - On mismatch: err_count+=1 and fail_vec[pattern]=1.
  - If pattern==3, go to FIN. Otherwise pattern+=1, cnt=0, go to HOLD; the new pattern appears on a_out/b_out in the next cycle.
- FIN (one cycle):
  - done=1; pass=(err_count==0); busy=0; {a_out,b_out}=00; go to IDLE.
- Timing:
  - Each pattern occupies SETTLE+1 cycles.
  - done is high exactly 4*(SETTLE+1)+1 cycles after the edge that sampled start (13 cycles for SETTLE=2).
  - busy is high from the cycle after start through the last SAMPLE cycle.
- Sweep boundaries:
  - start while busy, or during FIN, is ignored.
  - start held high continuously retriggers one cycle after FIN, i.e. back-to-back sweeps.
  - pass is cleared to 0 on a new accepted start.
  - pattern does not wrap: the sweep ends at 3.
  - err_count cannot exceed 4, so no saturation logic is needed.
- z_in is treated as an asynchronous-free, same-clock-domain signal unless GATE_BIST_SYNC_EN is defined.

Optional Feature:
- Macro: GATE_BIST_SYNC_EN.
- When defined:
  - z_in passes through a 2-flop synchronizer, reset to 0, before comparison.
  - The HOLD length becomes SETTLE+2 cycles, so the synchronized sample corresponds to the current pattern.
  - done latency is 4*(SETTLE+3)+1 cycles.
- When undefined:
  - z_in is compared directly, with the latency given above and no extra flops.

Test Plan:
- Correct OR GUT, TRUTH=4'b1110, SETTLE=2, pulse start -> a_out/b_out sequence 00,01,10,11 with 3 cycles each; done pulse 13 cycles after start; pass=1, err_count=0, fail_vec=0000.
- z_in tied to 0, TRUTH=4'b1110 -> done; pass=0, err_count=3, fail_vec=4'b1110.
- AND gate as GUT, TRUTH=4'b1110 -> pass=0, err_count=2, fail_vec=4'b0110.
- Reset, then start, then extra start pulses at cycles 4 and 9 -> only one sweep occurs, done fires once at cycle 13. Next, rst_n=0 at cycle 6 -> all outputs return to 0 immediately, no done pulse; a fresh start after reset completes normally with pass=1.
- start held high for 30 cycles with correct GUT -> two consecutive sweeps; done pulses at cycles 13 and 27; pass=1 after each.
- GATE_BIST_SYNC_EN defined, SETTLE=2, correct GUT -> done at cycle 21, pass=1. Same setup with z_in tied to 1 -> err_count=1, fail_vec=4'b0001.
